rom_readback: RTL and testbench

ROM_READBACK -- requirements
Module: rom_readback

---
 rtl/rom_readback.sv | 135 +++++++++++++
 tb/tb_rom_readback.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_readback.sv
// Avalon-MM readback bridge: fetches single bytes from a PRG or CHR ROM with a fixed read latency.
// Define ROM_READBACK_CSUM_EN to build the running 16-bit checksum of captured bytes.
module rom_readback #(
  parameter int unsigned RD_LAT = 2  // ROM latency from strobe to data, 1..4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_avl_addr,
  input  logic        i_avl_cs,
  input  logic        i_avl_read,
  input  logic        i_avl_write,
  input  logic [31:0] i_avl_writedata,
  output logic [31:0] o_avl_readdata,
  output logic [15:0] o_rom_addr,
  output logic        o_prg_rom_read,
  output logic        o_chr_rom_read,
  input  logic [7:0]  i_rom_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  localparam logic [2:0] LatCnt = 3'(RD_LAT);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_lat_cnt;
  logic [15:0] r_ptr;
  logic        r_prg;
  logic        r_auto;
  logic        r_valid;
  logic [7:0]  r_byte;
  logic [31:0] r_readdata;

  logic        w_wr_en;
  logic        w_ptr_wr;
  logic        w_rd_en;
  logic        w_consume;
  logic        w_capture;
  logic        w_busy;
  logic [31:0] w_rdata;
  logic [31:0] w_csum_rd;
  logic        w_unused;

  assign w_unused  = ^i_avl_writedata[29:16];

  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign w_wr_en   = i_avl_cs & i_avl_write;
  assign w_ptr_wr  = w_wr_en & (i_avl_addr == 2'd0);
  assign w_rd_en   = i_avl_cs & i_avl_read & ~i_avl_write;
  assign w_consume = w_rd_en & (i_avl_addr == 2'd1) & r_valid;
  assign w_capture = (r_state == StWait) & (r_lat_cnt == LatCnt) & ~w_ptr_wr;
  assign w_busy    = (r_state == StIssue) | (r_state == StWait);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  w_state_nxt = StIdle;
      StIssue: w_state_nxt = StWait;
      StWait:  if (r_lat_cnt == LatCnt) w_state_nxt = StHold;
      StHold:  if (w_consume) w_state_nxt = r_auto ? StIssue : StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_ptr_wr) w_state_nxt = StIssue;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_en) begin
      case (i_avl_addr)
        2'd1:    if (r_valid) w_rdata = {23'b0, 1'b1, r_byte};
        2'd2:    w_rdata = {r_ptr, 12'b0, r_prg, r_auto, r_valid, w_busy};
        2'd3:    w_rdata = w_csum_rd;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_lat_cnt  <= 3'd0;
      r_ptr      <= 16'h0000;
      r_prg      <= 1'b0;
      r_auto     <= 1'b0;
      r_valid    <= 1'b0;
      r_byte     <= 8'h00;
      r_readdata <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_readdata <= w_rdata;
      // Count cycles since the strobe; ISSUE is cycle 0.
      if (r_state == StIssue) begin
        r_lat_cnt <= 3'd1;
      end else if (r_state == StWait) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end
      if (w_ptr_wr) begin
        r_ptr   <= i_avl_writedata[15:0];
        r_prg   <= i_avl_writedata[31];
        r_auto  <= i_avl_writedata[30];
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_byte  <= i_rom_rdata;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
        if (r_auto) r_ptr <= r_ptr + 16'd1;
      end
    end
  end

`ifdef ROM_READBACK_CSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= 16'h0000;
    end else if (w_ptr_wr) begin
      r_csum <= 16'h0000;
    end else if (w_capture) begin
      r_csum <= r_csum + {8'h00, i_rom_rdata};
    end
  end

  assign w_csum_rd = {16'h0000, r_csum};
`else
  assign w_csum_rd = 32'h0;
`endif

  assign o_avl_readdata = r_readdata;
  assign o_rom_addr     = r_ptr;
  assign o_prg_rom_read = (r_state == StIssue) &  r_prg;
  assign o_chr_rom_read = (r_state == StIssue) & ~r_prg;

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: directed vector table, abort/reset sequences, and random traffic
// against a timestamp-based model of the register behaviour.
module tb_rom_readback;

  localparam int RD_LAT = 2;
`ifdef ROM_READBACK_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic        clk;
  logic        i_rst_n;
  logic [1:0]  i_avl_addr;
  logic        i_avl_cs;
  logic        i_avl_read;
  logic        i_avl_write;
  logic [31:0] i_avl_writedata;
  logic [31:0] o_avl_readdata;
  logic [15:0] o_rom_addr;
  logic        o_prg_rom_read;
  logic        o_chr_rom_read;
  logic [7:0]  i_rom_rdata;

  rom_readback #(.RD_LAT(RD_LAT)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_avl_addr      (i_avl_addr),
    .i_avl_cs        (i_avl_cs),
    .i_avl_read      (i_avl_read),
    .i_avl_write     (i_avl_write),
    .i_avl_writedata (i_avl_writedata),
    .o_avl_readdata  (o_avl_readdata),
    .o_rom_addr      (o_rom_addr),
    .o_prg_rom_read  (o_prg_rom_read),
    .o_chr_rom_read  (o_chr_rom_read),
    .i_rom_rdata     (i_rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int n_strobes = 0;

  typedef struct {
    bit          v;
    bit          prg;
    logic [15:0] a;
  } strb_t;
  strb_t hist[5];

  // Model: a fetch becomes visible a fixed number of cycles after its start.
  logic [15:0] m_ptr;
  logic        m_prg, m_auto, m_active, m_capt;
  logic [15:0] m_csum;
  logic [7:0]  m_byte;
  int          m_ready, m_strobe_cyc;
  logic        m_s_prg;
  logic [15:0] m_s_addr;
  logic [31:0] m_exp_rd;

  function automatic logic [7:0] rom_byte(logic prg, logic [15:0] a);
    if (prg && a == 16'h1234) return 8'hA5;
    if (!prg && a == 16'hFFFE) return 8'h11;
    if (!prg && a == 16'hFFFF) return 8'h22;
    if (!prg && a == 16'h0000) return 8'h33;
    return a[7:0] ^ a[15:8] ^ (prg ? 8'h5A : 8'hC3);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_ptr = 16'h0; m_prg = 1'b0; m_auto = 1'b0; m_active = 1'b0; m_capt = 1'b0;
    m_csum = 16'h0; m_byte = 8'h0; m_ready = 0; m_strobe_cyc = -1;
    m_s_prg = 1'b0; m_s_addr = 16'h0; m_exp_rd = 32'h0;
  endtask

  task automatic start_fetch(int c);
    m_active = 1'b1;
    m_capt = 1'b0;
    m_ready = c + RD_LAT + 2;
    m_strobe_cyc = c + 1;
    m_s_prg = m_prg;
    m_s_addr = m_ptr;
    m_byte = rom_byte(m_prg, m_ptr);
  endtask

  task automatic model_op(bit cs, bit rd, bit wr, logic [1:0] a, logic [31:0] wd);
    logic [31:0] e;
    e = 32'h0;
    if (m_active && !m_capt && cyc_n >= m_ready) begin
      m_capt = 1'b1;
      m_csum = m_csum + {8'h00, m_byte};
    end
    if (cs && wr) begin
      if (a == 2'd0) begin
        m_ptr = wd[15:0]; m_prg = wd[31]; m_auto = wd[30]; m_csum = 16'h0;
        start_fetch(cyc_n);
      end
    end else if (cs && rd) begin
      case (a)
        2'd1: if (m_active && m_capt) begin
          e = {23'b0, 1'b1, m_byte};
          if (m_auto) begin
            m_ptr = m_ptr + 16'd1;
            start_fetch(cyc_n);
          end else begin
            m_active = 1'b0;
            m_capt = 1'b0;
          end
        end
        2'd2: e = {m_ptr, 12'b0, m_prg, m_auto, m_active && m_capt, m_active && !m_capt};
        2'd3: e = CsumEn ? {16'h0, m_csum} : 32'h0;
        default: e = 32'h0;
      endcase
    end
    m_exp_rd = e;
  endtask

  // Advance to the next negedge, check per-cycle outputs and drive the ROM model.
  task automatic cyc();
    bit s, exp_s;
    @(negedge clk);
    cyc_n++;
    s = o_prg_rom_read | o_chr_rom_read;
    exp_s = (cyc_n == m_strobe_cyc);
    chk("strobe_excl", 32'(o_prg_rom_read & o_chr_rom_read), 32'h0);
    chk("strobe", 32'(s), 32'(exp_s));
    if (exp_s) begin
      chk("strobe_sel", 32'(o_prg_rom_read), 32'(m_s_prg));
      chk("strobe_addr", 32'(o_rom_addr), 32'(m_s_addr));
    end
    chk("rom_addr", 32'(o_rom_addr), 32'(m_ptr));
    if (s) n_strobes++;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = '{v: s, prg: o_prg_rom_read, a: o_rom_addr};
    i_rom_rdata = hist[RD_LAT].v ? rom_byte(hist[RD_LAT].prg, hist[RD_LAT].a) : 8'($urandom);
    chk("rdata", o_avl_readdata, m_exp_rd);
  endtask

  task automatic step(bit cs, bit rd, bit wr, logic [1:0] a, logic [31:0] wd);
    cyc();
    i_avl_cs = cs; i_avl_read = rd; i_avl_write = wr; i_avl_addr = a; i_avl_writedata = wd;
    model_op(cs, rd, wr, a, wd);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  typedef struct {
    bit          cs, rd, wr;
    logic [1:0]  a;
    logic [31:0] wd;
    int          pre;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(bit cs, bit rd, bit wr, logic [1:0] a, logic [31:0] wd, int pre,
                              logic [31:0] exp);
    vec_t v;
    v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.pre = pre; v.exp = exp;
    return v;
  endfunction

  vec_t vt[23];

  initial begin
    int s0;
    vt[0]  = mk(1, 0, 1, 2'd0, 32'h8000_1234, 0, 32'h0);
    vt[1]  = mk(1, 1, 0, 2'd1, 32'h0, 2, 32'h0000_01A5);
    vt[2]  = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h1234_0008);
    vt[3]  = mk(1, 0, 1, 2'd0, 32'h4000_FFFE, 0, 32'h0);
    vt[4]  = mk(1, 1, 0, 2'd1, 32'h0, 2, 32'h0000_0111);
    vt[5]  = mk(1, 1, 0, 2'd1, 32'h0, 2, 32'h0000_0122);
    vt[6]  = mk(1, 1, 0, 2'd1, 32'h0, 2, 32'h0000_0133);
    vt[7]  = mk(1, 1, 0, 2'd3, 32'h0, 0, CsumEn ? 32'h0000_0066 : 32'h0);
    vt[8]  = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h0001_0006);
    vt[9]  = mk(1, 0, 1, 2'd0, 32'h8000_0100, 0, 32'h0);
    vt[10] = mk(1, 1, 0, 2'd1, 32'h0, 0, 32'h0);
    vt[11] = mk(1, 1, 0, 2'd1, 32'h0, 0, 32'h0000_015B);
    vt[12] = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h0100_0008);
    vt[13] = mk(1, 0, 1, 2'd0, 32'h8000_0300, 0, 32'h0);
    vt[14] = mk(1, 1, 0, 2'd2, 32'h0, 2, 32'h0300_000A);
    vt[15] = mk(1, 1, 1, 2'd0, 32'h8000_0301, 0, 32'h0);
    vt[16] = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h0301_0009);
    vt[17] = mk(0, 0, 1, 2'd0, 32'h4000_1111, 0, 32'h0);
    vt[18] = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h0301_000A);
    vt[19] = mk(1, 1, 0, 2'd0, 32'h0, 0, 32'h0);
    vt[20] = mk(1, 1, 0, 2'd1, 32'h0, 0, 32'h0000_0158);
    vt[21] = mk(1, 0, 1, 2'd2, 32'hFFFF_FFFF, 0, 32'h0);
    vt[22] = mk(1, 1, 0, 2'd2, 32'h0, 0, 32'h0301_0008);

    for (int i = 0; i < 5; i++) hist[i] = '{v: 1'b0, prg: 1'b0, a: 16'h0};
    model_reset();
    i_rst_n = 1'b0; i_avl_cs = 1'b0; i_avl_read = 1'b0; i_avl_write = 1'b0;
    i_avl_addr = 2'd0; i_avl_writedata = 32'h0; i_rom_rdata = 8'h0;
    #1;
    chk("rst_rdata", o_avl_readdata, 32'h0);
    chk("rst_rom_addr", 32'(o_rom_addr), 32'h0);
    chk("rst_strobes", 32'({o_prg_rom_read, o_chr_rom_read}), 32'h0);
    idle(); idle();
    i_rst_n = 1'b1;
    idle(); idle();

    for (int i = 0; i < 23; i++) begin
      repeat (vt[i].pre) idle();
      step(vt[i].cs, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd);
      idle();
      chk($sformatf("vec%0d", i), o_avl_readdata, vt[i].exp);
    end

    // Abort during WAIT: only the second fetch may be captured.
    s0 = n_strobes;
    step(1, 0, 1, 2'd0, 32'h8000_0500);
    idle();
    step(1, 0, 1, 2'd0, 32'h8000_0010);
    idle(); idle(); idle();
    step(1, 1, 0, 2'd1, 32'h0);
    idle();
    chk("abort_data", o_avl_readdata, 32'h0000_014A);
    chk("abort_strobes", 32'(n_strobes - s0), 32'd2);
    step(1, 1, 0, 2'd3, 32'h0);
    idle();
    chk("abort_csum", o_avl_readdata, CsumEn ? 32'h0000_004A : 32'h0);

    // Reset asserted while waiting on ROM data.
    step(1, 0, 1, 2'd0, 32'h8000_0600);
    idle(); idle();
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rdata", o_avl_readdata, 32'h0);
    chk("midrst_rom_addr", 32'(o_rom_addr), 32'h0);
    chk("midrst_strobes", 32'({o_prg_rom_read, o_chr_rom_read}), 32'h0);
    idle(); idle();
    i_rst_n = 1'b1;
    s0 = n_strobes;
    repeat (8) idle();
    chk("postrst_strobes", 32'(n_strobes - s0), 32'd0);
    step(1, 1, 0, 2'd2, 32'h0);
    idle();
    chk("postrst_status", o_avl_readdata, 32'h0);
    step(1, 1, 0, 2'd3, 32'h0);
    idle();
    chk("postrst_csum", o_avl_readdata, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [15:0] p;
      r = $urandom_range(0, 99);
      p = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      if (r < 10)      step(1, 0, 1, 2'd0, {1'($urandom), 1'($urandom), 14'($urandom), p});
      else if (r < 50) step(1, 1, 0, 2'd1, 32'h0);
      else if (r < 62) step(1, 1, 0, 2'd2, 32'h0);
      else if (r < 70) step(1, 1, 0, 2'd3, 32'h0);
      else if (r < 74) step(1, 1, 1, 2'($urandom), {1'($urandom), 1'($urandom), 14'h0, p});
      else if (r < 80) step(0, 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      else if (r < 84) step(1, 0, 1, 2'($urandom_range(1, 3)), $urandom);
      else             idle();
    end
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
